// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared constants and types for the register-file write arbiter
package regfile_write_arbiter_pkg;

    localparam int REG_WIDTH  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ZERO_REG   = 0;

    // Which requester wins when both are valid in the same cycle.
    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// rtl/regfile_write_arbiter_rr_arb2.sv - two-requester round-robin arbiter with stall
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   stall       suppresses all grants while high
//   req[1:0]    requests; bit 0 is requester A, bit 1 is requester B
//   gnt[1:0]    one-hot (or zero) grant, combinational from req/stall/state
module rr_arb2
    import regfile_write_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    prio_t state;
    prio_t state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PRIO_A;
        end else begin
            state <= state_next;
        end
    end

    // A requester that loses a tie is favoured on the next granted cycle,
    // so neither side waits more than one non-stalled cycle.
    always_comb begin
        gnt        = 2'b00;
        state_next = state;
        if (!stall) begin
            if (req[0] && (!req[1] || state == PRIO_A)) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
        if (gnt[0]) begin
            state_next = PRIO_B;
        end else if (gnt[1]) begin
            state_next = PRIO_A;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register-file write port between two requesters
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   stall                      blocks all grants while high
//   a_valid/a_ready/a_addr/a_data  requester A write handshake
//   b_valid/b_ready/b_addr/b_data  requester B write handshake
//   wr_enable/wr_addr/wr_data  registered register-file write port
//   zero_drops                 saturating count of accepted writes to register 0
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int WIDTH  = REG_WIDTH,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [WIDTH-1:0]  a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [WIDTH-1:0]  b_data,
    output logic              wr_enable,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic [CNT_W-1:0]  zero_drops
);

    logic [1:0]        gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [WIDTH-1:0]  sel_data;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .req   ({b_valid, a_valid}),
        .gnt   (gnt)
    );

    assign a_ready  = gnt[0];
    assign b_ready  = gnt[1];
    assign sel_addr = gnt[1] ? b_addr : a_addr;
    assign sel_data = gnt[1] ? b_data : a_data;

    // Single output register: the file never back-pressures, so an accepted
    // write always lands here on the next edge. Writes to register 0 update
    // addr/data but never raise wr_enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_enable  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            zero_drops <= '0;
        end else begin
            wr_enable <= 1'b0;
            if (|gnt) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
                if (sel_addr == ADDR_W'(ZERO_REG)) begin
                    if (zero_drops != '1) begin
                        zero_drops <= zero_drops + CNT_W'(1);
                    end
                end else begin
                    wr_enable <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for the register-file write arbiter
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        wr_enable;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  zero_drops;

    int checks   = 0;
    int failures = 0;

    regfile_write_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .wr_enable  (wr_enable),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .zero_drops (zero_drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who won most recently decides ties; an accepted write
    // appears on the output one cycle later; drops are counted as plain integers.
    bit m_last_was_a;
    bit m_en;
    int m_addr;
    longint m_data;
    int m_drops;

    function automatic bit model_grant_a();
        return !stall && a_valid && (!b_valid || m_last_was_a == 1'b0);
    endfunction

    function automatic bit model_grant_b();
        return !stall && b_valid && !model_grant_a();
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last_was_a <= 1'b0;
            m_en         <= 1'b0;
            m_addr       <= 0;
            m_data       <= 0;
            m_drops      <= 0;
        end else if (model_grant_a() || model_grant_b()) begin
            if (model_grant_a()) begin
                m_last_was_a <= 1'b1;
                m_addr       <= int'(a_addr);
                m_data       <= longint'(a_data);
                m_en         <= (a_addr != 0);
                if (a_addr == 0) m_drops <= (m_drops < 255) ? m_drops + 1 : 255;
            end else begin
                m_last_was_a <= 1'b0;
                m_addr       <= int'(b_addr);
                m_data       <= longint'(b_data);
                m_en         <= (b_addr != 0);
                if (b_addr == 0) m_drops <= (m_drops < 255) ? m_drops + 1 : 255;
            end
        end else begin
            m_en <= 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp_a_ready",    64'(a_ready),    64'(model_grant_a()));
            chk("cmp_b_ready",    64'(b_ready),    64'(model_grant_b()));
            chk("cmp_one_hot",    64'(a_ready & b_ready), 64'(0));
            chk("cmp_wr_enable",  64'(wr_enable),  64'(m_en));
            chk("cmp_wr_addr",    64'(wr_addr),    64'(m_addr));
            chk("cmp_wr_data",    64'(wr_data),    64'(m_data));
            chk("cmp_zero_drops", 64'(zero_drops), 64'(m_drops));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        stall   = 1'b0;
        a_valid = 1'b0;
        a_addr  = '0;
        a_data  = '0;
        b_valid = 1'b0;
        b_addr  = '0;
        b_data  = '0;

        // Reset then idle.
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_wr_enable",  64'(wr_enable),  64'(0));
            chk("idle_wr_addr",    64'(wr_addr),    64'(0));
            chk("idle_wr_data",    64'(wr_data),    64'(0));
            chk("idle_zero_drops", 64'(zero_drops), 64'(0));
        end

        // Single write from A.
        tick();
        a_valid = 1'b1;
        a_addr  = 5'd7;
        a_data  = 32'd3426527914;
        @(negedge clk);
        chk("single_a_ready", 64'(a_ready), 64'(1));
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        chk("single_wr_enable", 64'(wr_enable), 64'(1));
        chk("single_wr_addr",   64'(wr_addr),   64'(7));
        chk("single_wr_data",   64'(wr_data),   64'(32'd3426527914));
        @(negedge clk);
        chk("single_after_en",   64'(wr_enable), 64'(0));
        chk("single_after_addr", 64'(wr_addr),   64'(7));
        chk("single_after_data", 64'(wr_data),   64'(32'd3426527914));

        // Contention straight out of reset: grants alternate A, B, A, B...
        tick();
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        a_valid = 1'b1;
        a_addr  = 5'd3;
        a_data  = 32'h11;
        b_valid = 1'b1;
        b_addr  = 5'd4;
        b_data  = 32'h22;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("cont_a_ready", 64'(a_ready), 64'((i % 2) == 0));
            chk("cont_b_ready", 64'(b_ready), 64'((i % 2) == 1));
            if (i == 1) begin
                chk("cont_c1_en",   64'(wr_enable), 64'(1));
                chk("cont_c1_addr", 64'(wr_addr),   64'(3));
                chk("cont_c1_data", 64'(wr_data),   64'(32'h11));
            end
            if (i == 2) begin
                chk("cont_c2_en",   64'(wr_enable), 64'(1));
                chk("cont_c2_addr", 64'(wr_addr),   64'(4));
                chk("cont_c2_data", 64'(wr_data),   64'(32'h22));
            end
            tick();
            if ((i % 2) == 0) begin
                a_addr = a_addr + 5'd2;
                a_data = a_data + 32'h22;
            end else begin
                b_addr = b_addr + 5'd2;
                b_data = b_data + 32'h22;
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        chk("cont_last_en", 64'(wr_enable), 64'(1));
        chk("cont_last_addr", 64'(wr_addr), 64'(8));

        // Writes to register 0 are counted, never committed.
        tick();
        b_valid = 1'b1;
        b_addr  = 5'd0;
        b_data  = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("zero_b_ready", 64'(b_ready), 64'(1));
        tick();
        @(negedge clk);
        chk("zero_wr_enable", 64'(wr_enable),  64'(0));
        chk("zero_drops_one", 64'(zero_drops), 64'(1));
        repeat (300) tick();
        b_valid = 1'b0;
        @(negedge clk);
        chk("zero_drops_sat", 64'(zero_drops), 64'(255));
        chk("zero_sat_en",    64'(wr_enable),  64'(0));

        // Stall blocks grants; the pending write goes out once stall drops.
        tick();
        stall   = 1'b1;
        a_valid = 1'b1;
        a_addr  = 5'd10;
        a_data  = 32'hCAFE_0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_a_ready",   64'(a_ready),   64'(0));
            chk("stall_wr_enable", 64'(wr_enable), 64'(0));
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("unstall_a_ready", 64'(a_ready), 64'(1));
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        chk("unstall_wr_enable", 64'(wr_enable), 64'(1));
        chk("unstall_wr_addr",   64'(wr_addr),   64'(10));

        // Reset lands while an accepted write sits in the output register.
        tick();
        a_valid = 1'b1;
        a_addr  = 5'd9;
        a_data  = 32'h0000_0099;
        @(negedge clk);
        chk("midrst_a_ready", 64'(a_ready), 64'(1));
        tick();
        a_valid = 1'b0;
        chk("midrst_inflight_en", 64'(wr_enable), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_wr_enable", 64'(wr_enable), 64'(0));
        chk("midrst_wr_addr",   64'(wr_addr),   64'(0));
        chk("midrst_wr_data",   64'(wr_data),   64'(0));
        chk("midrst_drops",     64'(zero_drops), 64'(0));
        tick();
        rst_n   = 1'b1;
        a_valid = 1'b1;
        a_addr  = 5'd12;
        a_data  = 32'h12;
        b_valid = 1'b1;
        b_addr  = 5'd13;
        b_data  = 32'h13;
        @(negedge clk);
        chk("postrst_a_ready", 64'(a_ready), 64'(1));
        chk("postrst_b_ready", 64'(b_ready), 64'(0));
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        chk("postrst_b_ready2", 64'(b_ready), 64'(1));
        chk("postrst_wr_addr",  64'(wr_addr), 64'(12));
        tick();
        b_valid = 1'b0;
        @(negedge clk);
        chk("postrst_wr_addr2", 64'(wr_addr), 64'(13));
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file (register32 array, register 0 hardwired to zero via register32zero) between two write-back requesters, A and B.
- Each requester uses a valid/ready handshake. Arbitration is round-robin.
- Each accepted write is registered and driven to the register file's wrenable/address/data one cycle later.
- Writes to address 0 are accepted but never reach the file; they are counted instead.

Parameters:
- WIDTH, 32, data width of register-file entries.
- ADDR_W, 5, register address width (32 entries).
- CNT_W, 8, width of the saturating dropped-zero-write counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  while high, no grants are issued (register file held, e.g. during debug readout).
- a_valid  in  1  requester A has a write pending.
- a_ready  out  1  A's write is accepted this cycle.
- a_addr  in  ADDR_W  A destination register.
- a_data  in  WIDTH  A write data.
- b_valid  in  1  requester B has a write pending.
- b_ready  out  1  B's write is accepted this cycle.
- b_addr  in  ADDR_W  B destination register.
- b_data  in  WIDTH  B write data.
- wr_enable  out  1  to register-file wrenable; registered.
- wr_addr  out  ADDR_W  to register-file write decoder; registered.
- wr_data  out  WIDTH  to register-file d inputs; registered.
- zero_drops  out  CNT_W  number of accepted writes to address 0, saturating.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately, including mid-transfer):
  - wr_enable=0, wr_addr=0, wr_data=0, zero_drops=0.
  - Priority state = PRIO_A.
  - An output-stage write in flight is discarded.
- Priority FSM, two states: PRIO_A (A wins a tie), PRIO_B (B wins a tie).
  - After any cycle with a grant to A, next state = PRIO_B.
  - After any cycle with a grant to B, next state = PRIO_A.
  - No grant: state holds.
- Grant logic (combinational from valids, stall and state; ready depends on valid, which is allowed):
  - stall=1: a_ready=b_ready=0.
  - Otherwise, only A valid: a_ready=1. Only B valid: b_ready=1. Both valid: the requester favoured by the state gets ready=1, the other gets 0.
  - At most one ready is high in any cycle.
- Requester rule: once valid is asserted, addr/data stay stable and valid stays high until ready. A rejected requester wins the following non-stalled cycle, so it never waits more than one non-stalled cycle.
- Output stage (latency 1): on the edge after an accepted transfer:
  - wr_addr and wr_data take the winner's addr/data.
  - wr_enable=1 if addr!=0, else wr_enable=0 and zero_drops increments.
  - zero_drops saturates at 2^CNT_W-1 (255) and does not wrap.
- Cycle with no acceptance: wr_enable=0 next cycle; wr_addr and wr_data hold their previous values.
- Back-to-back acceptances produce consecutive wr_enable pulses; there are no bubbles and full throughput is one write per cycle.
- Stall asserted in the same cycle as a valid: nothing is accepted and the FSM holds. The pending write issues on the first cycle stall is low.
- Both requesters targeting the same address in consecutive cycles: the writes commit in grant order, so the later grant's data remains in the file.
- No internal write buffering beyond the single output register. The register file never back-pressures, so no ready depends on the output stage.

Decomposition:
- Shared package holds:
  - Constants REG_WIDTH=32, REG_ADDR_W=5, ZERO_REG=0.
  - Two-state enum prio_t {PRIO_A, PRIO_B}.
- One natural sub-module: rr_arb2. It is a two-requester round-robin arbiter with the priority FSM, taking req[1:0] and stall, and producing gnt[1:0].
- The top level adds the output register and the zero-drop counter.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release, no valids -> wr_enable=0, wr_addr=0, wr_data=0, zero_drops=0 for 5 cycles.
- Single write: A valid, addr=7, data=3426527914 -> a_ready=1 same cycle; next cycle wr_enable=1, wr_addr=7, wr_data=3426527914; the cycle after, wr_enable=0 and addr/data held.
- Contention: A (addr=3, data=0x11) and B (addr=4, data=0x22) valid from reset -> A granted in cycle 0, B in cycle 1; wr_enable high in cycles 1–2 with addr 3 then 4. Keep both continuously valid with new data for 4 cycles -> grants alternate A, B, A, B.
- Zero register: B writes addr=0, data=0xFFFFFFFF -> b_ready=1, wr_enable stays 0, zero_drops=1. Then 300 such writes -> zero_drops=255.
- Stall: A valid with stall=1 for 3 cycles -> a_ready=0, wr_enable=0 throughout. Drop stall -> a_ready=1, and wr_enable=1 on the next cycle.
- Reset mid-operation: A is accepted (addr=9), then rst_n pulsed low before the next rising edge -> wr_enable reads 0 immediately and no write to register 9 occurs. Priority returns to PRIO_A, so if both requesters are valid after release, A wins.
